sq_drain_ctrl: RTL
==================

SQ_DRAIN_CTRL -- requirements
Module: sq_drain_ctrl

Interface
REQ-001 SHALL have parameter SQ_SIZE_LOG, default 3, meaning log2 of store-queue depth.
REQ-002 SHALL have parameter DATA_W, default 64, meaning width of store addr/data/mask fields.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  pipeline flush, synchronous.
REQ-006 SHALL have port head_valid  input  1  head store-queue entry holds a store.
REQ-007 SHALL have port head_ready_to_go  input  1  head entry valid and committed.
REQ-008 SHALL have port head_mmio  input  1  head entry is an MMIO store.
REQ-009 SHALL have ports head_store_addr, head_store_data, head_store_mask  input  DATA_W each  head entry payload.
REQ-010 SHALL have port head_store_ls_size  input  4  head entry access size.
REQ-011 SHALL have port head_ptr  output  SQ_SIZE_LOG+1  head index with wrap bit in MSB.
REQ-012 SHALL have port head_issuing  output  1  one-cycle dequeue pulse to the head entry.
REQ-013 SHALL have port mmio_stall  output  1  committed MMIO store at head, not drained here.
REQ-014 SHALL have ports dcache_req_valid  output  1, and dcache_req_ready  input  1  write-request handshake.
REQ-015 SHALL have ports dcache_req_addr, dcache_req_data, dcache_req_mask  output  DATA_W each, and dcache_req_size  output  4  request payload.
REQ-016 SHALL have port dcache_resp_valid  input  1  write-completion pulse.
REQ-017 SHALL have port busy  output  1  FSM not in IDLE.

Function
REQ-018 SHALL implement states IDLE, REQ, RESP, ABORT.
REQ-019 IDLE -> REQ when head_ready_to_go & ~head_mmio & ~flush; payload latched into request registers on that edge.
REQ-020 REQ: dcache_req_valid=1 with latched payload held stable; REQ -> RESP on cycle dcache_req_valid & dcache_req_ready.
REQ-021 RESP -> IDLE on dcache_resp_valid; same edge head_issuing pulses for exactly one cycle and head_ptr increments by 1.
REQ-022 head_ptr SHALL wrap from index 2^SQ_SIZE_LOG-1 to 0 and toggle MSB wrap bit on wrap.
REQ-023 Minimum store latency: IDLE-accept to head_issuing = 2 cycles with dcache_req_ready=1 and response one cycle after handshake; next store accepted the cycle after head_issuing.
REQ-024 Payload inputs SHALL NOT affect outputs after latching in IDLE.
REQ-025 mmio_stall = (state==IDLE) & head_ready_to_go & head_mmio; no dcache request for MMIO entries.
REQ-026 flush in IDLE or REQ (before handshake): -> IDLE, dcache_req_valid deasserted next cycle, no head_issuing, head_ptr reset to 0.
REQ-027 flush in RESP: -> ABORT, head_ptr reset to 0; ABORT waits for dcache_resp_valid, then -> IDLE with no head_issuing; new request not accepted while in ABORT.
REQ-028 flush coincident with dcache_resp_valid in RESP: -> IDLE, no head_issuing, head_ptr=0.
REQ-029 flush coincident with REQ handshake: handshake counts; -> ABORT.
REQ-030 head_valid=0 with head_ready_to_go=1 SHALL be treated as not ready.
REQ-031 busy = state != IDLE.

Reset
REQ-032 On reset_n low: state=IDLE, head_ptr=0, head_issuing=0, dcache_req_valid=0, request payload registers=0, mmio_stall=0, busy=0.
REQ-033 Reset asserted mid-operation SHALL abandon any outstanding request immediately with no head_issuing.

Verification
REQ-034 Single store addr=0x8000_0010, data=0xDEAD_BEEF, mask=0xF, size=2, ready=1, resp 1 cycle later -> one request with those values, head_issuing 2 cycles after accept, head_ptr 0->1.
REQ-035 dcache_req_ready held low 5 cycles -> dcache_req_valid and payload stable all 5 cycles, no head_issuing until resp.
REQ-036 Eight back-to-back stores from head_ptr=0 with SQ_SIZE_LOG=3 -> head_ptr ends 4'b1000 (index 0, wrap bit 1).
REQ-037 Committed MMIO at head -> mmio_stall=1, dcache_req_valid=0, head_ptr unchanged.
REQ-038 flush one cycle after REQ handshake, resp 3 cycles later -> ABORT held 3 cycles, no head_issuing, head_ptr=0, IDLE after resp.
REQ-039 reset_n pulsed low while in RESP -> all outputs at reset values immediately, later dcache_resp_valid ignored.

Source files
------------

// File: rtl/sq_drain_ctrl.sv
// sq_drain_ctrl: drains committed stores from the store-queue head into the dcache
// Ports:
//   clock, reset_n                         clock and asynchronous active-low reset
//   flush                                  synchronous pipeline flush
//   head_valid, head_ready_to_go, head_mmio  status of the store-queue head entry
//   head_store_addr/data/mask/ls_size      head entry payload, sampled on accept
//   head_ptr                               head index, MSB is the wrap bit
//   head_issuing                           one-cycle dequeue pulse to the head entry
//   mmio_stall                             committed MMIO store waiting at head
//   dcache_req_valid/ready, dcache_req_*   dcache write request and payload
//   dcache_resp_valid                      dcache write completion
//   busy                                   drain FSM is not idle
module sq_drain_ctrl #(
  parameter int SQ_SIZE_LOG = 3,
  parameter int DATA_W      = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   head_valid,
  input  logic                   head_ready_to_go,
  input  logic                   head_mmio,
  input  logic [DATA_W-1:0]      head_store_addr,
  input  logic [DATA_W-1:0]      head_store_data,
  input  logic [DATA_W-1:0]      head_store_mask,
  input  logic [3:0]             head_store_ls_size,
  output logic [SQ_SIZE_LOG:0]   head_ptr,
  output logic                   head_issuing,
  output logic                   mmio_stall,
  output logic                   dcache_req_valid,
  input  logic                   dcache_req_ready,
  output logic [DATA_W-1:0]      dcache_req_addr,
  output logic [DATA_W-1:0]      dcache_req_data,
  output logic [DATA_W-1:0]      dcache_req_mask,
  output logic [3:0]             dcache_req_size,
  input  logic                   dcache_resp_valid,
  output logic                   busy
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, ABORT} state_t;
  state_t state, state_nxt;
  logic head_go, accept, handshake, issue;
  assign head_go          = head_valid & head_ready_to_go;
  assign accept           = (state == IDLE) & head_go & ~head_mmio & ~flush;
  assign dcache_req_valid = (state == REQ);
  assign handshake        = dcache_req_valid & dcache_req_ready;
  assign busy             = (state != IDLE);
  // gated by reset_n so the stall indication is quiet while reset is held
  assign mmio_stall       = reset_n & (state == IDLE) & head_go & head_mmio;
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE:  state_nxt = accept ? REQ : IDLE;
      // an accepted handshake commits the dcache to a response, so a flush then must wait in ABORT
      REQ:   state_nxt = handshake ? (flush ? ABORT : RESP) : (flush ? IDLE : REQ);
      RESP: begin
        state_nxt = dcache_resp_valid ? IDLE : (flush ? ABORT : RESP);
        issue     = dcache_resp_valid & ~flush;
      end
      ABORT: state_nxt = dcache_resp_valid ? IDLE : ABORT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      head_ptr        <= '0;
      head_issuing    <= 1'b0;
      dcache_req_addr <= '0;
      dcache_req_data <= '0;
      dcache_req_mask <= '0;
      dcache_req_size <= '0;
    end else begin
      state        <= state_nxt;
      head_issuing <= issue;
      // natural overflow of the extra MSB provides the wrap toggle
      head_ptr     <= flush ? '0 : head_ptr + {{SQ_SIZE_LOG{1'b0}}, issue};
      if (accept) begin
        dcache_req_addr <= head_store_addr;
        dcache_req_data <= head_store_data;
        dcache_req_mask <= head_store_mask;
        dcache_req_size <= head_store_ls_size;
      end
    end
  end
endmodule
